// File: rtl/shift_seq.sv
// Multi-cycle sequencer that drives an external combinational barrel shifter for register-specified shifts.
// Optional SHIFT_SEQ_FAST32_EN: LSL/LSR/ASR chunks up to 32, with 32 issued as the shifter's offset-0 encoding.
module shift_seq #(
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             req_rrx,
    input  logic [31:0]      req_op,
    input  logic             req_carry_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_carry,
    output logic             busy,
    output logic [1:0]       sh_type,
    output logic [4:0]       sh_offset,
    output logic [31:0]      sh_op,
    output logic             sh_carry_in,
    input  logic [31:0]      sh_result,
    input  logic             sh_carry
);

`ifdef SHIFT_SEQ_FAST32_EN
    localparam int CHUNK_CAP = 32;
`else
    localparam int CHUNK_CAP = 31;
`endif
    localparam logic [AMT_W-1:0] CHUNK_MAX = AMT_W'(CHUNK_CAP);
    localparam logic [1:0]       TYPE_ROR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       type_q;
    logic             cin_q;
    logic             rrx_q;
    logic [31:0]      acc;
    logic             cy;
    logic [AMT_W-1:0] rem;

    logic             req_rrx_eff;
    logic             bypass_zero;
    logic             bypass_ror;
    logic [AMT_W-1:0] chunk;
    logic [AMT_W-1:0] rem_nx;
    logic             is_ror;
    logic             last_step;
    logic [4:0]       step_offset;

    // RRX is only meaningful on ROR; a stray req_rrx on other types is ignored.
    assign req_rrx_eff = req_rrx && (req_type == TYPE_ROR);
    assign bypass_zero = !req_rrx_eff && (req_amount == '0);
    assign bypass_ror  = !req_rrx_eff && (req_type == TYPE_ROR) &&
                         (req_amount != '0) && (req_amount[4:0] == 5'd0);

    // A chunk of 32 truncates to offset 0, which the shifter treats as by-32.
    assign is_ror      = (type_q == TYPE_ROR);
    assign chunk       = (rem > CHUNK_MAX) ? CHUNK_MAX : rem;
    assign rem_nx      = rem - chunk;
    assign last_step   = is_ror || (rem_nx == '0);
    assign step_offset = is_ror ? (rrx_q ? 5'd0 : rem[4:0]) : chunk[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sh_offset = 5'd0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = (bypass_zero || bypass_ror) ? DONE : STEP;
                end
            end
            STEP: begin
                sh_offset = step_offset;
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Accumulator chains shifter passes; cy carries the most recent carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q <= 2'b00;
            cin_q  <= 1'b0;
            rrx_q  <= 1'b0;
            acc    <= 32'h0;
            cy     <= 1'b0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        type_q <= req_type;
                        cin_q  <= req_carry_in;
                        rrx_q  <= req_rrx_eff;
                        acc    <= req_op;
                        rem    <= req_amount;
                        if (bypass_zero) begin
                            cy <= req_carry_in;
                        end else if (bypass_ror) begin
                            cy <= req_op[31];
                        end
                    end
                end
                STEP: begin
                    acc <= sh_result;
                    cy  <= sh_carry;
                    rem <= is_ror ? '0 : rem_nx;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign resp_valid  = (state == DONE);
    assign resp_result = acc;
    assign resp_carry  = cy;
    assign sh_type     = type_q;
    assign sh_op       = acc;
    assign sh_carry_in = cin_q;

endmodule
